period_meter: RTL and testbench

Measures the number of clock cycles between consecutive single-cycle pulses and reports each interval as a registered value with a one-cycle valid strobe. It is the measuring counterpart of the load-and-count-down timer: the timer turns a 9-bit value into a pulse train, and this block turns a pulse train back into a 9-bit value. It sits downstream of any tick or beat source and feeds period-dependent logic or a display.

---
 rtl/period_meter_pkg.sv | 12 +
 rtl/period_meter_sat_counter.sv | 36 +++
 rtl/period_meter.sv | 83 ++++++++
 tb/tb_period_meter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: state encoding and default counter width.
package period_meter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 9;
  localparam int unsigned PERIOD_MAX    = (1 << DEFAULT_WIDTH) - 1;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

endpackage

// File: rtl/period_meter_sat_counter.sv
// Saturating interval counter with synchronous clear-to-0, clear-to-1 and a sticky sat flag.
module sat_counter #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_zero,
  input  logic             clear_one,
  input  logic             incr,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  localparam logic [WIDTH-1:0] CountMax = {WIDTH{1'b1}};

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clear_zero) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clear_one) begin
      count <= {{(WIDTH-1){1'b0}}, 1'b1};
      sat   <= 1'b0;
    end else if (incr) begin
      // sat flags an interval that ran past the max, not one that just reached it
      if (count == CountMax) begin
        sat <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/period_meter.sv
// Measures clock cycles between consecutive pulses; reports each interval with a valid strobe.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             count_en,
  input  logic             pulse_in,
  output logic [WIDTH-1:0] period_out,
  output logic             period_valid,
  output logic             overflow,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             clear_zero, clear_one, incr, capture;
  logic [WIDTH-1:0] count;
  logic             sat;

  sat_counter #(
    .WIDTH(WIDTH)
  ) u_sat_counter (
    .clock     (clock),
    .reset     (reset),
    .clear_zero(clear_zero),
    .clear_one (clear_one),
    .incr      (incr),
    .count     (count),
    .sat       (sat)
  );

  always_comb begin
    state_d    = state_q;
    clear_zero = 1'b0;
    clear_one  = 1'b0;
    incr       = 1'b0;
    capture    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_en && pulse_in) begin
          state_d   = MEASURE;
          clear_one = 1'b1;
        end else begin
          clear_zero = 1'b1;
        end
      end
      MEASURE: begin
        // count_en outranks a coincident pulse
        if (!count_en) begin
          state_d    = IDLE;
          clear_zero = 1'b1;
        end else if (pulse_in) begin
          capture   = 1'b1;
          clear_one = 1'b1;
        end else begin
          incr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      period_out   <= '0;
      period_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_valid <= capture;
      if (capture) begin
        period_out <= count;
        overflow   <= sat;
      end
    end
  end

  assign busy = (state_q == MEASURE);

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: timestamp-based reference model plus directed and random stimulus.
module tb_period_meter;
  import period_meter_pkg::*;

  localparam int unsigned W = DEFAULT_WIDTH;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         count_en = 1'b0;
  logic         pulse_in = 1'b0;
  logic [W-1:0] period_out;
  logic         period_valid;
  logic         overflow;
  logic         busy;

  int compared   = 0;
  int mismatched = 0;

  period_meter #(
    .WIDTH(W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .count_en    (count_en),
    .pulse_in    (pulse_in),
    .period_out  (period_out),
    .period_valid(period_valid),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  // Reference model: remembers the cycle of the last accepted pulse and derives intervals
  longint t = 0;
  longint last_t = 0;
  bit     armed = 0;
  bit     model_on = 0;
  int     e_period = 0;
  bit     e_valid = 0;
  bit     e_ovf = 0;
  bit     e_busy = 0;

  always @(posedge clock) begin
    longint d;
    t = t + 1;
    if (!reset) begin
      armed = 0; e_period = 0; e_valid = 0; e_ovf = 0; e_busy = 0;
      model_on = 1;
    end else begin
      e_valid = 0;
      if (!count_en) begin
        armed = 0;
      end else if (pulse_in) begin
        if (armed) begin
          d = t - last_t;
          e_period = (d > PERIOD_MAX) ? PERIOD_MAX : int'(d);
          e_ovf    = (d > PERIOD_MAX);
          e_valid  = 1;
        end
        armed  = 1;
        last_t = t;
      end
      e_busy = armed;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at t=%0d: got %0d, expected %0d", name, t, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    if (model_on) begin
      chk("period_valid", int'(period_valid), int'(e_valid));
      chk("busy", int'(busy), int'(e_busy));
      chk("period_out", int'(period_out), e_period);
      chk("overflow", int'(overflow), int'(e_ovf));
    end
  end

  task automatic cyc(input bit rst_n, input bit en, input bit p);
    reset    = rst_n;
    count_en = en;
    pulse_in = p;
    @(posedge clock);
    #1;
  endtask

  // n-1 quiet cycles then one pulse: an interval of n from the previous pulse
  task automatic gap(input int n);
    for (int i = 0; i < n - 1; i++) cyc(1, 1, 0);
    cyc(1, 1, 1);
  endtask

  // Literal expectations pin both the model and the DUT
  task automatic check_cap(input string name, input int val, input bit ovf);
    chk({name, " model_val"}, e_period, val);
    chk({name, " model_ovf"}, int'(e_ovf), int'(ovf));
    chk({name, " valid"}, int'(period_valid), 1);
    chk({name, " value"}, int'(period_out), val);
    chk({name, " ovf"}, int'(overflow), int'(ovf));
  endtask

  initial begin
    int prob;
    // Reset with pulses active
    cyc(0, 1, 1);
    cyc(0, 1, 1);
    chk("reset busy", int'(busy), 0);
    chk("reset valid", int'(period_valid), 0);
    chk("reset period", int'(period_out), 0);
    chk("reset ovf", int'(overflow), 0);

    // Steady train of 65
    cyc(1, 1, 1);
    chk("first pulse busy", int'(busy), 1);
    chk("first pulse valid", int'(period_valid), 0);
    for (int k = 0; k < 3; k++) begin
      gap(65);
      check_cap("train65", 65, 0);
    end

    // Boundaries
    cyc(1, 1, 1);
    check_cap("back2back", 1, 0);
    gap(511);
    check_cap("int511", 511, 0);
    gap(600);
    check_cap("int600", 511, 1);
    gap(20);
    check_cap("int20", 20, 0);

    // Abort mid-interval
    cyc(1, 0, 0);
    chk("idle busy", int'(busy), 0);
    cyc(1, 1, 1);
    for (int i = 0; i < 29; i++) cyc(1, 1, 0);
    cyc(1, 0, 0);
    chk("abort busy", int'(busy), 0);
    chk("abort valid", int'(period_valid), 0);
    chk("abort hold", int'(period_out), 20);
    cyc(1, 1, 1);
    chk("rearm valid", int'(period_valid), 0);
    gap(40);
    check_cap("after_abort", 40, 0);

    // count_en low with pulse: no capture
    cyc(1, 0, 1);
    chk("prio valid", int'(period_valid), 0);
    chk("prio busy", int'(busy), 0);
    chk("prio hold", int'(period_out), 40);

    // Reset mid-interval
    cyc(1, 1, 1);
    for (int i = 0; i < 24; i++) cyc(1, 1, 0);
    cyc(0, 1, 0);
    chk("midreset busy", int'(busy), 0);
    chk("midreset period", int'(period_out), 0);
    cyc(1, 1, 1);
    chk("post reset valid", int'(period_valid), 0);
    gap(10);
    check_cap("post_reset", 10, 0);

    // 3-cycle-wide pulse
    for (int i = 0; i < 5; i++) cyc(1, 1, 0);
    cyc(1, 1, 1);
    check_cap("wide_first", 6, 0);
    cyc(1, 1, 1);
    check_cap("wide_second", 1, 0);
    cyc(1, 1, 1);
    check_cap("wide_third", 1, 0);
    cyc(1, 1, 0);
    chk("wide end valid", int'(period_valid), 0);

    // Random: varied pulse densities, occasional aborts and resets
    for (int blk = 0; blk < 8; blk++) begin
      case (blk % 4)
        0: prob = 2;
        1: prob = 20;
        2: prob = 300;
        default: prob = 700;
      endcase
      for (int i = 0; i < 1500; i++) begin
        cyc(($urandom_range(0, 999) != 0),
            ($urandom_range(0, 499) != 0),
            ($urandom_range(0, prob - 1) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
